// File: rtl/bp_pkg.sv
// Shared decode constants, counter encoding and immediate/counter helpers for the
// fetch-stage branch predictor.
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Sign-extended B-type immediate.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // Sign-extended J-type immediate.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // Saturating increment, holds at strongly-taken.
  function automatic ctr_t sat_inc(input ctr_t ctr);
    return (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
  endfunction

  // Saturating decrement, holds at strongly-not-taken.
  function automatic ctr_t sat_dec(input ctr_t ctr);
    return (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Table of 2-bit saturating direction counters.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (every entry -> CTR_INIT)
//   rd_idx       asynchronous read index
//   rd_ctr_c     counter at rd_idx (combinational, pre-update value)
//   wr_en        apply one saturating update this cycle
//   wr_idx       entry to update
//   wr_taken     1 = increment, 0 = decrement
module bht_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter ctr_t        CTR_INIT = CTR_WNT,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t ctr_q [ENTRIES];

  // Saturating update; reset restores every entry regardless of clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= wr_taken ? sat_inc(ctr_q[wr_idx]) : sat_dec(ctr_q[wr_idx]);
    end
  end

  // No bypass: a same-cycle write becomes visible on the next cycle.
  assign rd_ctr_c = ctr_q[rd_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage direction predictor: PC-indexed 2-bit counters, optionally hashed
// with a speculative global history (gshare). Decodes B-type/JAL in IF and
// produces next_pc; trained from EX, with history repair on a mispredict.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_pc, if_inst, if_stall instruction in IF; stall blocks the history shift
//   next_pc, predict         combinational prediction for the IF instruction
//   pred_ghr                 history used for this prediction (carried to EX)
//   upd_valid/pc/ghr/pred/taken  resolved B-type from EX
//   mispredict               combinational direction-mispredict flag
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned GHR_BITS    = 6,
  parameter ctr_t        CTR_INIT    = CTR_WNT,
  localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES),
  localparam int unsigned GHR_W      = (GHR_BITS == 0) ? 1 : GHR_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             if_stall,
  output logic [31:0]      next_pc,
  output logic             predict,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_pred,
  input  logic             upd_taken,
  output logic             mispredict
);

  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  ctr_t             rd_ctr;
  logic             is_branch;
  logic             is_jal;
  logic             unused_bits;

  assign is_branch  = (if_inst[6:0] == OPC_BRANCH);
  assign is_jal     = (if_inst[6:0] == OPC_JAL);
  assign mispredict = upd_valid & (upd_pred != upd_taken);
  assign pred_ghr   = ghr_q;

  // Index hash: word-aligned PC bits XOR zero-extended history (bimodal when GHR_BITS=0).
  always_comb begin
    rd_idx = if_pc[IDX_W+1:2];
    wr_idx = upd_pc[IDX_W+1:2];
    if (GHR_BITS != 0) begin
      rd_idx = rd_idx ^ IDX_W'(ghr_q);
      wr_idx = wr_idx ^ IDX_W'(upd_ghr);
    end
  end

  bht_counter_table #(
    .ENTRIES  (BHT_ENTRIES),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_ctr_c (rd_ctr),
    .wr_en    (upd_valid),
    .wr_idx   (wr_idx),
    .wr_taken (upd_taken)
  );

  // Direction and next fetch address; targets always come from the immediate.
  always_comb begin
    predict = 1'b0;
    next_pc = if_pc + 32'd4;
    if (is_branch) begin
      predict = rd_ctr[1];
      if (rd_ctr[1]) begin
        next_pc = if_pc + imm_b(if_inst);
      end
    end else if (is_jal) begin
      predict = 1'b1;
      next_pc = if_pc + imm_j(if_inst);
    end
  end

  // History next-state: EX repair outranks the speculative IF shift; JAL never shifts.
  // The truncating casts drop the oldest bit, which also covers a 1-bit history.
  always_comb begin
    ghr_d = ghr_q;
    if (GHR_BITS != 0) begin
      if (mispredict) begin
        ghr_d = GHR_W'({upd_ghr, upd_taken});
      end else if (is_branch && !if_stall) begin
        ghr_d = GHR_W'({ghr_q, predict});
      end
    end
  end

  // History register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Only the index bits of upd_pc and the direction bit of the counter are consumed.
  assign unused_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0], rd_ctr[0]};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench: a bimodal instance (GHR_BITS=0) and a gshare instance
// (GHR_BITS=4) share stimulus and are compared every cycle against a behavioural
// model, plus literal expectations for the directed scenarios.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_stall = 1'b0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [3:0]  upd_ghr4 = '0;
  logic [0:0]  upd_ghr0 = '0;
  logic        upd_pred = 1'b0;
  logic        upd_taken = 1'b0;

  logic [31:0] next_pc0, next_pc4;
  logic        predict0, predict4;
  logic [0:0]  pred_ghr0;
  logic [3:0]  pred_ghr4;
  logic        mis0, mis4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: counter values 0..3 per entry and the 4-bit history as an integer.
  int m_ctr0 [64];
  int m_ctr4 [64];
  int m_ghr4;

  always #5 clk = ~clk;

  gshare_branch_predictor #(.BHT_ENTRIES(64), .GHR_BITS(0), .CTR_INIT(2'b01)) dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_stall(if_stall),
    .next_pc(next_pc0), .predict(predict0), .pred_ghr(pred_ghr0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr0), .upd_pred(upd_pred),
    .upd_taken(upd_taken), .mispredict(mis0));

  gshare_branch_predictor #(.BHT_ENTRIES(64), .GHR_BITS(4), .CTR_INIT(2'b01)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_stall(if_stall),
    .next_pc(next_pc4), .predict(predict4), .pred_ghr(pred_ghr4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr4), .upd_pred(upd_pred),
    .upd_taken(upd_taken), .mispredict(mis4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm);
    logic [20:0] i;
    i = 21'(imm);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction

  // Immediates rebuilt arithmetically from the instruction fields.
  function automatic int m_imm_b(input logic [31:0] x);
    int v;
    v = x[31] ? -4096 : 0;
    v += int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
    return v;
  endfunction

  function automatic int m_imm_j(input logic [31:0] x);
    int v;
    v = x[31] ? -1048576 : 0;
    v += int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
    return v;
  endfunction

  function automatic int m_idx(input logic [31:0] pc, input int h);
    return int'((pc / 32'd4) % 32'd64) ^ h;
  endfunction

  // Expected predict/next_pc for the current IF inputs; g4 selects the gshare instance.
  function automatic void m_out(input bit g4, output bit p, output logic [31:0] n);
    logic [6:0] opc;
    int c;
    opc = if_inst[6:0];
    p = 1'b0;
    n = if_pc + 32'd4;
    if (opc == 7'h63) begin
      c = g4 ? m_ctr4[m_idx(if_pc, m_ghr4)] : m_ctr0[m_idx(if_pc, 0)];
      p = (c >= 2);
      if (p) n = if_pc + 32'(m_imm_b(if_inst));
    end else if (opc == 7'h6F) begin
      p = 1'b1;
      n = if_pc + 32'(m_imm_j(if_inst));
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr0[i] = 1;
      m_ctr4[i] = 1;
    end
    m_ghr4 = 0;
  endfunction

  function automatic int bump(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  // Clock-edge model step: predictions use pre-update state, then train and shift.
  function automatic void model_step();
    bit p4;
    logic [31:0] n4;
    int i0, i4;
    if (rst) return;
    m_out(1'b1, p4, n4);
    if (upd_valid) begin
      i0 = m_idx(upd_pc, 0);
      i4 = m_idx(upd_pc, int'(upd_ghr4));
      m_ctr0[i0] = bump(m_ctr0[i0], upd_taken);
      m_ctr4[i4] = bump(m_ctr4[i4], upd_taken);
    end
    if (upd_valid && (upd_pred != upd_taken))
      m_ghr4 = (int'(upd_ghr4) * 2 + int'(upd_taken)) % 16;
    else if (if_inst[6:0] == 7'h63 && !if_stall)
      m_ghr4 = (m_ghr4 * 2 + int'(p4)) % 16;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [3:0] h, input bit t, input bit pr, input int n);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr4 = h; upd_taken = t; upd_pred = pr;
    repeat (n) cyc();
    upd_valid = 1'b0;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp
    bit p;
    logic [31:0] n;
    bit mis;
    m_out(1'b0, p, n);
    chk("predict0", 32'(predict0), 32'(p));
    chk("next_pc0", next_pc0, n);
    m_out(1'b1, p, n);
    chk("predict4", 32'(predict4), 32'(p));
    chk("next_pc4", next_pc4, n);
    chk("pred_ghr4", 32'(pred_ghr4), 32'(m_ghr4));
    chk("pred_ghr0", 32'(pred_ghr0), 32'd0);
    mis = upd_valid && (upd_pred != upd_taken);
    chk("mispredict0", 32'(mis0), 32'(mis));
    chk("mispredict4", 32'(mis4), 32'(mis));
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // 1: reset state, BEQ +16 at 0x100 predicts not-taken.
    if_pc = 32'h100; if_inst = enc_b(16);
    #1;
    chk("t1_predict", 32'(predict0), 32'd0);
    chk("t1_next_pc", next_pc0, 32'h104);

    // 2: two taken updates, both mispredicts; then predicted taken to 0x110.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_ghr4 = 4'h0; upd_taken = 1'b1; upd_pred = 1'b0;
    #1 chk("t2_mis_a", 32'(mis0), 32'd1);
    cyc();
    chk("t2_mis_b", 32'(mis0), 32'd1);
    cyc();
    upd_valid = 1'b0;
    #1;
    chk("t2_predict", 32'(predict0), 32'd1);
    chk("t2_next_pc", next_pc0, 32'h110);

    // 3: saturation at both ends.
    train(32'h100, 4'h0, 1'b1, 1'b1, 5);
    train(32'h100, 4'h0, 1'b0, 1'b1, 1);
    #1 chk("t3_after_11_dec", 32'(predict0), 32'd1);
    train(32'h100, 4'h0, 1'b0, 1'b0, 4);
    #1 chk("t3_floor", 32'(predict0), 32'd0);
    train(32'h100, 4'h0, 1'b1, 1'b0, 1);
    #1 chk("t3_no_wrap", 32'(predict0), 32'd0);

    // 4: three NT branches keep GHR at 0; repair beats a same-cycle IF shift.
    pulse_rst();
    if_pc = 32'h300; if_inst = enc_b(12); if_stall = 1'b0;
    repeat (3) cyc();
    chk("t4_ghr_zero", 32'(pred_ghr4), 32'h0);
    upd_valid = 1'b1; upd_pc = 32'h500; upd_ghr4 = 4'b0001; upd_pred = 1'b0; upd_taken = 1'b1;
    #1 chk("t4_mis", 32'(mis4), 32'd1);
    cyc();
    upd_valid = 1'b0;
    #1 chk("t4_repair", 32'(pred_ghr4), 32'b0011);

    // 5: JAL -8 does not shift history; branch target wraps past 2^32.
    if_pc = 32'h200; if_inst = enc_j(-8);
    #1;
    chk("t5_jal_pred", 32'(predict4), 32'd1);
    chk("t5_jal_npc", next_pc4, 32'h1F8);
    cyc();
    chk("t5_jal_ghr", 32'(pred_ghr4), 32'b0011);
    train(32'hFFFF_FFFC, 4'h0, 1'b1, 1'b1, 2);
    if_pc = 32'hFFFF_FFFC; if_inst = enc_b(8);
    #1;
    chk("t5_wrap_pred", 32'(predict0), 32'd1);
    chk("t5_wrap_npc", next_pc0, 32'h4);

    // 6: reset mid-sequence after training; stall blocks the speculative shift.
    if_pc = 32'h200; if_inst = enc_j(-8);
    train(32'h100, 4'h0, 1'b1, 1'b1, 2);
    if_pc = 32'h100; if_inst = enc_b(16);
    #1 chk("t6_trained", 32'(predict0), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_pred", 32'(predict0), 32'd0);
    chk("t6_rst_ghr", 32'(pred_ghr4), 32'h0);
    #1 rst = 1'b0;
    cyc();
    chk("t6_wnt_npc", next_pc0, 32'h104);
    if_pc = 32'h200; if_inst = enc_j(-8);
    train(32'h100, 4'h0, 1'b1, 1'b1, 2);
    if_pc = 32'h100; if_inst = enc_b(16); if_stall = 1'b1;
    #1 chk("t6_stall_pred", 32'(predict4), 32'd1);
    repeat (2) cyc();
    chk("t6_stall_ghr", 32'(pred_ghr4), 32'h0);
    if_stall = 1'b0;
    cyc();
    chk("t6_unstall_ghr", 32'(pred_ghr4), 32'h1);

    // Randomized traffic with aliasing PCs and occasional asynchronous resets.
    for (int k = 0; k < 800; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    if_inst = enc_b(int'($urandom_range(0, 8191)) - 4096);
        2:       if_inst = enc_j(int'($urandom_range(0, 2097151)) - 1048576);
        default: if_inst = $urandom();
      endcase
      case ($urandom_range(0, 4))
        0:       if_pc = 32'h100;
        1:       if_pc = 32'h140;
        2:       if_pc = 32'hFFFF_FFFC;
        3:       if_pc = {26'($urandom()), 4'($urandom()), 2'b00};
        default: if_pc = $urandom();
      endcase
      if_stall  = ($urandom_range(0, 3) == 0);
      upd_valid = 1'($urandom());
      case ($urandom_range(0, 2))
        0:       upd_pc = 32'h100;
        1:       upd_pc = 32'h140;
        default: upd_pc = $urandom();
      endcase
      upd_ghr4  = 4'($urandom());
      upd_pred  = 1'($urandom());
      upd_taken = 1'($urandom());
      if ($urandom_range(0, 63) == 0) pulse_rst();
      cyc();
    end

    upd_valid = 1'b0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
